// File: rtl/lcd_pkg.sv
// Shared command encodings, scheduler states and engine handshake helper for lcd_cmd_sched.
package lcd_pkg;

  localparam logic [2:0] CMD_WRITE  = 3'd0;
  localparam logic [2:0] CMD_SHIFTU = 3'd1;
  localparam logic [2:0] CMD_SHIFTD = 3'd2;
  localparam logic [2:0] CMD_SHIFTL = 3'd3;
  localparam logic [2:0] CMD_SHIFTR = 3'd4;
  localparam logic [2:0] CMD_ROTATE = 3'd5;
  localparam logic [2:0] CMD_MIRRX  = 3'd6;
  localparam logic [2:0] CMD_MIRRY  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    ISSUE,
    WAIT_WR
  } sched_state_t;

  // Engine accepts a command only when neither loading nor finishing write-back.
  function automatic logic eng_rdy(input logic busy, input logic done);
    return !busy && !done;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous per-requester command FIFO; extra pointer MSB distinguishes full from empty.
module lcd_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Two-requester frame scheduler for the LCD engine: per-frame grant, one command per ready slot.
// Define LCD_SCHED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CMD_W      = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  input  logic [CMD_W-1:0] req_cmd0,
  input  logic [CMD_W-1:0] req_cmd1,
  output logic [1:0]       req_ready,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  output logic             owner,
  output logic [1:0]       frame_done
);

  sched_state_t     state;
  logic             seen_busy;
  logic [1:0]       fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0] fifo_dout [2];
  logic [CMD_W-1:0] owner_cmd;
  logic             ready_now, pop_en, next_owner;

  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo0 (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_valid[0]),
    .din     (req_cmd0),
    .pop     (fifo_pop[0]),
    .dout    (fifo_dout[0]),
    .full    (fifo_full[0]),
    .empty   (fifo_empty[0])
  );

  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo1 (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_valid[1]),
    .din     (req_cmd1),
    .pop     (fifo_pop[1]),
    .dout    (fifo_dout[1]),
    .full    (fifo_full[1]),
    .empty   (fifo_empty[1])
  );

  assign req_ready = ~fifo_full;
  assign ready_now = eng_rdy(lcd_busy, lcd_done);
  assign owner_cmd = fifo_dout[owner];
  // Blocking on cmd_valid spaces issues at least two cycles apart.
  assign pop_en    = (state == ISSUE) && ready_now && !cmd_valid && !fifo_empty[owner];
  assign fifo_pop  = {pop_en && owner, pop_en && !owner};

`ifdef LCD_SCHED_PRIO_EN
  always_comb begin
    next_owner = fifo_empty[0];
  end
`else
  logic rr_ptr;

  always_comb begin
    next_owner = fifo_empty[0];
    if (fifo_empty == 2'b00) next_owner = rr_ptr;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      frame_done <= 2'b00;
      seen_busy  <= 1'b0;
`ifndef LCD_SCHED_PRIO_EN
      rr_ptr     <= 1'b0;
`endif
    end else begin
      cmd_valid  <= 1'b0;
      frame_done <= 2'b00;
      unique case (state)
        IDLE: begin
          if (fifo_empty != 2'b11) begin
            owner <= next_owner;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (ready_now) state <= ISSUE;
        end
        ISSUE: begin
          if (pop_en) begin
            cmd       <= owner_cmd;
            cmd_valid <= 1'b1;
            if (owner_cmd == CMD_W'(CMD_WRITE)) begin
              seen_busy <= 1'b0;
              state     <= WAIT_WR;
            end
          end
        end
        WAIT_WR: begin
          // Done only counts once the engine has visibly started the write-back.
          if (seen_busy && lcd_done) begin
            frame_done[owner] <= 1'b1;
`ifndef LCD_SCHED_PRIO_EN
            rr_ptr            <= !owner;
`endif
            state             <= IDLE;
          end else if (lcd_busy) begin
            seen_busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Randomized scoreboard bench for lcd_cmd_sched with a frame-level reference model and engine model.
module tb_lcd_cmd_sched;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [W-1:0] req_cmd0 = '0;
  logic [W-1:0] req_cmd1 = '0;
  logic [1:0]   req_ready;
  logic         lcd_busy = 1'b0;
  logic         lcd_done = 1'b0;
  logic [W-1:0] cmd;
  logic         cmd_valid;
  logic         owner;
  logic [1:0]   frame_done;

  lcd_cmd_sched #(.FIFO_DEPTH(4), .CMD_W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_cmd0   (req_cmd0),
    .req_cmd1   (req_cmd1),
    .req_ready  (req_ready),
    .lcd_busy   (lcd_busy),
    .lcd_done   (lcd_done),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .owner      (owner),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         own;
    logic [W-1:0] c;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];
  int   fd_q[$];
  logic [W-1:0] fr0[$];
  logic [W-1:0] fr1[$];
  int   rr_m = 0;
  bit   hold_busy = 0;
  int   stall_left = 0;
  int   wb_state = 0;
  int   wb_left = 0;
  bit   prev_cv = 0;
  bit   stall_act;
  exp_t mon_e;

  function automatic void check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor and engine model share one negedge process so their ordering is fixed.
  always @(negedge clk) begin
    if (!reset_n) begin
      wb_state   = 0;
      stall_left = 0;
      lcd_busy   = 1'b0;
      lcd_done   = 1'b0;
      prev_cv    = 0;
    end else begin
      if (cmd_valid) begin
        check("issue_while_not_ready", int'(lcd_busy | lcd_done), 0);
        check("issue_back_to_back", int'(prev_cv), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_cmd_valid", int'(cmd_valid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("cmd", int'(cmd), int'(mon_e.c));
          check("owner", int'(owner), int'(mon_e.own));
        end
      end
      prev_cv = cmd_valid;
      if (frame_done != 2'b00) begin
        if (fd_q.size() == 0) check("unexpected_frame_done", int'(frame_done), 0);
        else check("frame_done", int'(frame_done), 1 << fd_q.pop_front());
      end
      lcd_done = 1'b0;
      if (wb_state == 2) begin
        wb_state = 0;
        lcd_done = 1'b1;
      end else if (wb_state == 1) begin
        wb_left--;
        if (wb_left == 0) wb_state = 2;
      end else if (cmd_valid && cmd == '0) begin
        wb_state = 1;
        wb_left  = $urandom_range(2, 4);
      end
      stall_act = (stall_left > 0);
      if (stall_act) stall_left--;
      lcd_busy = hold_busy || (wb_state == 1) || stall_act;
    end
  end

  task automatic gen_frames(input bit en0, input bit en1);
    int n;
    fr0.delete();
    fr1.delete();
    if (en0) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n - 1; k++) fr0.push_back(W'($urandom_range(1, 7)));
      fr0.push_back('0);
    end
    if (en1) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n - 1; k++) fr1.push_back(W'($urandom_range(1, 7)));
      fr1.push_back('0);
    end
  endtask

  // Reference model: whole frames in grant order; a tie goes to the favoured requester.
  task automatic plan_frames();
    int   first, o;
    exp_t e;
    if (fr0.size() > 0 && fr1.size() > 0) begin
`ifdef LCD_SCHED_PRIO_EN
      first = 0;
`else
      first = rr_m;
`endif
    end else begin
      first = (fr0.size() > 0) ? 0 : 1;
    end
    for (int p = 0; p < 2; p++) begin
      o = (p == 0) ? first : 1 - first;
      if ((o == 0 && fr0.size() > 0) || (o == 1 && fr1.size() > 0)) begin
        e.own = o[0];
        if (o == 0) foreach (fr0[k]) begin e.c = fr0[k]; exp_q.push_back(e); end
        else        foreach (fr1[k]) begin e.c = fr1[k]; exp_q.push_back(e); end
        fd_q.push_back(o);
        rr_m = 1 - o;
      end
    end
  endtask

  task automatic drive_frames(input bit gaps, input bit stalls);
    int  i0 = 0;
    int  i1 = 0;
    bit  first = 1;
    while (i0 < fr0.size() || i1 < fr1.size()) begin
      @(negedge clk);
      req_valid = 2'b00;
      if (i0 < fr0.size() && req_ready[0] && (first || !gaps || $urandom_range(0, 3) != 0)) begin
        req_valid[0] = 1'b1;
        req_cmd0     = fr0[i0];
        i0++;
      end
      if (i1 < fr1.size() && req_ready[1] && (first || !gaps || $urandom_range(0, 3) != 0)) begin
        req_valid[1] = 1'b1;
        req_cmd1     = fr1[i1];
        i1++;
      end
      if (stalls && stall_left == 0 && $urandom_range(0, 5) == 0) stall_left = $urandom_range(1, 4);
      first = 0;
    end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || fd_q.size() != 0 || wb_state != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size() + fd_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  logic [W-1:0] ov[5];
  exp_t         ex;
  int           sz, cnt, n;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 3);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", int'(req_ready), 3);
    check("rel_cmd_valid", int'(cmd_valid), 0);
    check("rel_frame_done", int'(frame_done), 0);
    check("rel_owner", int'(owner), 0);

    // Both requesters push full frames in the same cycle
    fr0 = '{3'd1, 3'd2, 3'd3, 3'd0};
    fr1 = '{3'd4, 3'd5, 3'd6, 3'd0};
    plan_frames();
    drive_frames(0, 0);
    wait_idle();

    // Single requester frame 1,3,5,WRITE
    fr0 = '{3'd1, 3'd3, 3'd5, 3'd0};
    fr1.delete();
    plan_frames();
    drive_frames(0, 0);
    wait_idle();

    // Overflow: five back-to-back pushes into requester 1 while the engine holds off
    hold_busy = 1;
    repeat (2) @(negedge clk);
    ov = '{3'd2, 3'd4, 3'd6, 3'd0, 3'd7};
    ex.own = 1'b1;
    for (int k = 0; k < 4; k++) begin ex.c = ov[k]; exp_q.push_back(ex); end
    fd_q.push_back(1);
    rr_m = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) check("ovf_ready_low", int'(req_ready[1]), 0);
      req_valid = 2'b10;
      req_cmd1  = ov[k];
    end
    @(negedge clk);
    req_valid = 2'b00;
    check("ovf_still_full", int'(req_ready), 1);
    hold_busy = 0;
    wait_idle();

    // Ten-cycle engine reload in the middle of a frame
    hold_busy = 1;
    fr0 = '{3'd1, 3'd2, 3'd3, 3'd0};
    fr1.delete();
    plan_frames();
    drive_frames(0, 0);
    hold_busy = 0;
    n = 0;
    while (exp_q.size() > 3 && n < 100) begin @(negedge clk); n++; end
    check("stall_first_issued", exp_q.size(), 3);
    stall_left = 10;
    repeat (2) @(negedge clk);
    sz  = exp_q.size();
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (cmd_valid) cnt++;
    end
    check("stall_no_issue", cnt, 0);
    check("stall_queue_held", exp_q.size(), sz);
    wait_idle();

    // Randomized frames: both, only 0, only 1, with push gaps and engine stalls
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(0, 2);
      gen_frames(n != 2, n != 1);
      plan_frames();
      drive_frames(1, 1);
      wait_idle();
    end

    // Reset during write-back: nothing completes, queued requester-1 commands vanish
    ex.own = 1'b0;
    ex.c = 3'd4; exp_q.push_back(ex);
    ex.c = 3'd0; exp_q.push_back(ex);
    fd_q.push_back(0);
    @(negedge clk); req_valid = 2'b01; req_cmd0 = 3'd4;
    @(negedge clk); req_valid = 2'b11; req_cmd0 = 3'd0; req_cmd1 = 3'd3;
    @(negedge clk); req_valid = 2'b10; req_cmd1 = 3'd5;
    @(negedge clk); req_valid = 2'b00;
    n = 0;
    while (wb_state != 1 && n < 100) begin @(negedge clk); n++; end
    check("wr_reached_writeback", wb_state, 1);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    fd_q.delete();
    rr_m = 0;
    #1;
    check("mid_rst_cmd_valid", int'(cmd_valid), 0);
    check("mid_rst_frame_done", int'(frame_done), 0);
    check("mid_rst_owner", int'(owner), 0);
    check("mid_rst_req_ready", int'(req_ready), 3);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_req_ready", int'(req_ready), 3);
    check("post_rst_owner", int'(owner), 0);

    // Scheduler still works after the mid-frame reset
    gen_frames(1, 1);
    plan_frames();
    drive_frames(1, 0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
